// File: rtl/seq_multiplier_if.sv
// -----------------------------------------------------------------------------
// seq_multiplier_if
//   Request/response bundle between a requester (ALU sequencer) and the
//   iterative shift-add multiplier.
//
//   start       requester -> multiplier  operation request, honoured in IDLE
//   signed_mode requester -> multiplier  1 = two's-complement operands
//   a, b        requester -> multiplier  multiplicand / multiplier (SIZE bits)
//   busy        multiplier -> requester  high while iterating
//   done        multiplier -> requester  one-cycle pulse when c is updated
//   c           multiplier -> requester  2*SIZE-bit product register
// -----------------------------------------------------------------------------
interface seq_multiplier_if #(
  parameter int SIZE = 8
);
  logic              start;
  logic              signed_mode;
  logic [SIZE-1:0]   a;
  logic [SIZE-1:0]   b;
  logic              busy;
  logic              done;
  logic [2*SIZE-1:0] c;

  // Requester side.
  modport master (
    output start, signed_mode, a, b,
    input  busy, done, c
  );

  // Multiplier side.
  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, c
  );
endinterface : seq_multiplier_if

// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//   Iterative shift-add multiplier. Multiplies two SIZE-bit operands (unsigned
//   or two's-complement) into a 2*SIZE-bit product over SIZE iteration cycles.
//   Signed operands are reduced to magnitudes on acceptance; the product sign
//   is reapplied when the result is written to c.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset; abandons any operation in flight
//     bus    seq_multiplier_if.slave (start, signed_mode, a, b, busy, done, c)
//
//   Timing: start sampled at edge k -> busy during cycles k+1..k+SIZE,
//   done=1 and c valid in the cycle after edge k+SIZE, then back to IDLE.
// -----------------------------------------------------------------------------
module seq_multiplier #(
  parameter int SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_multiplier_if.slave      bus
);

  localparam int PW    = 2 * SIZE;
  localparam int CNT_W = $clog2(SIZE + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Operand/iteration registers.
  logic [PW-1:0]    mcand_q;   // multiplicand, shifted left each iteration
  logic [SIZE-1:0]  mplier_q;  // multiplier, shifted right each iteration
  logic [PW-1:0]    acc_q;     // partial product
  logic [CNT_W-1:0] cnt_q;     // iterations remaining
  logic             neg_q;     // product must be negated on completion
  logic [PW-1:0]    c_q;       // visible product register

  // Combinational helpers.
  logic [SIZE-1:0]  mag_a;
  logic [SIZE-1:0]  mag_b;
  logic             neg_in;
  logic [PW-1:0]    acc_sum;
  logic [PW-1:0]    result;
  logic             last_iter;
  logic             busy_o;
  logic             done_o;

  // ---------------------------------------------------------------------------
  // Operand conditioning. A SIZE-bit unsigned magnitude holds 2^(SIZE-1), so
  // negating the most negative value needs no extra bit.
  // ---------------------------------------------------------------------------
  always_comb begin
    mag_a  = bus.a;
    mag_b  = bus.b;
    neg_in = 1'b0;
    if (bus.signed_mode) begin
      if (bus.a[SIZE-1]) mag_a = -bus.a;
      if (bus.b[SIZE-1]) mag_b = -bus.b;
      neg_in = bus.a[SIZE-1] ^ bus.b[SIZE-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Iteration datapath: conditional add of the shifted multiplicand. Negating a
  // zero product yields zero, so a zero operand never produces a nonzero sign.
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_sum   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    result    = neg_q ? (~acc_sum + PW'(1)) : acc_sum;
    last_iter = (cnt_q == CNT_W'(1));
  end

  // ---------------------------------------------------------------------------
  // FSM state register.
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and decoded outputs.
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is given a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = CALC;
      end
      CALC: begin
        busy_o = 1'b1;
        if (last_iter) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers. c is written only on the DONE-entry edge, so it holds
  // the last product through IDLE and the next operation.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      c_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            mcand_q  <= {{SIZE{1'b0}}, mag_a};
            mplier_q <= mag_b;
            acc_q    <= '0;
            cnt_q    <= CNT_W'(SIZE);
            neg_q    <= neg_in;
          end
        end
        CALC: begin
          acc_q    <= acc_sum;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CNT_W'(1);
          if (last_iter) c_q <= result;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_o;
  assign bus.done = done_o;
  assign bus.c    = c_q;

endmodule : seq_multiplier

// File: tb/tb_seq_multiplier.sv
// -----------------------------------------------------------------------------
// tb_seq_multiplier
//   Self-checking bench for seq_multiplier at SIZE=8 and SIZE=2. Expected
//   products are queued when a request is issued and compared when done pulses.
// -----------------------------------------------------------------------------
module tb_seq_multiplier;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seq_multiplier_if #(.SIZE(8)) m8 ();
  seq_multiplier_if #(.SIZE(2)) m2 ();

  seq_multiplier #(.SIZE(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(m8.slave));
  seq_multiplier #(.SIZE(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(m2.slave));

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] exp_q8[$];
  logic [3:0]  exp_q2[$];
  int          done_cnt8 = 0;
  int          done_cnt2 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: compare c against the oldest queued expectation on each done.
  always @(negedge clk) begin
    if (m8.done === 1'b1) begin
      done_cnt8++;
      if (exp_q8.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL done8_unexpected: done with c=0x%0h, expected no done", m8.c);
      end else begin
        check("c8_on_done", 32'(m8.c), 32'(exp_q8.pop_front()));
      end
    end
    if (m2.done === 1'b1) begin
      done_cnt2++;
      if (exp_q2.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL done2_unexpected: done with c=0x%0h, expected no done", m2.c);
      end else begin
        check("c2_on_done", 32'(m2.c), 32'(exp_q2.pop_front()));
      end
    end
  end

  typedef struct {
    bit          s2;    // 1 = SIZE=2 instance
    logic        sm;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic logic get_busy(input bit s2);
    return s2 ? m2.busy : m8.busy;
  endfunction

  function automatic logic get_done(input bit s2);
    return s2 ? m2.done : m8.done;
  endfunction

  function automatic logic [15:0] get_c(input bit s2);
    return s2 ? 16'(m2.c) : m8.c;
  endfunction

  // Must be called in a negedge slot with the target DUT in IDLE; returns in
  // the IDLE cycle right after done.
  task automatic do_op(input vec_t v);
    int n;
    if (v.s2) begin
      m2.start = 1'b1; m2.signed_mode = v.sm; m2.a = v.a[1:0]; m2.b = v.b[1:0];
      exp_q2.push_back(v.exp[3:0]);
    end else begin
      m8.start = 1'b1; m8.signed_mode = v.sm; m8.a = v.a; m8.b = v.b;
      exp_q8.push_back(v.exp);
    end
    @(negedge clk);
    // Scramble operands after sampling; the operation in flight must not care.
    if (v.s2) begin
      m2.start = 1'b0; m2.a = ~m2.a; m2.b = ~m2.b; m2.signed_mode = ~v.sm;
    end else begin
      m8.start = 1'b0; m8.a = ~m8.a; m8.b = ~m8.b; m8.signed_mode = ~v.sm;
    end
    n = 0;
    while (get_busy(v.s2) === 1'b1 && n < 64) begin
      n++;
      @(negedge clk);
    end
    check({v.name, "_busy_cycles"}, 32'(n), v.s2 ? 32'd2 : 32'd8);
    check({v.name, "_done_high"}, 32'(get_done(v.s2)), 32'd1);
    @(negedge clk);
    check({v.name, "_done_low"}, 32'(get_done(v.s2)), 32'd0);
    check({v.name, "_c_hold"}, 32'(get_c(v.s2)), 32'(v.s2 ? 16'(v.exp[3:0]) : v.exp));
  endtask

  initial begin
    int d0;
    int n;
    vec_t v;

    vecs.push_back('{0, 1'b0, 8'hFF, 8'hFF, 16'hFE01, "u_ff_ff"});
    vecs.push_back('{0, 1'b1, 8'hFD, 8'h05, 16'hFFF1, "s_m3_5"});
    vecs.push_back('{0, 1'b1, 8'h80, 8'h80, 16'h4000, "s_min_min"});
    vecs.push_back('{0, 1'b1, 8'h80, 8'h7F, 16'hC080, "s_min_max"});
    vecs.push_back('{0, 1'b0, 8'h00, 8'hA5, 16'h0000, "u_zero"});
    vecs.push_back('{0, 1'b1, 8'h00, 8'hFF, 16'h0000, "s_zero_m1"});
    vecs.push_back('{0, 1'b1, 8'hFF, 8'hFF, 16'h0001, "s_m1_m1"});
    vecs.push_back('{0, 1'b1, 8'h7F, 8'h7F, 16'h3F01, "s_max_max"});
    vecs.push_back('{0, 1'b0, 8'h80, 8'h80, 16'h4000, "u_80_80"});
    vecs.push_back('{0, 1'b0, 8'h80, 8'h7F, 16'h3F80, "u_80_7f"});
    vecs.push_back('{1, 1'b0, 8'h03, 8'h00, 16'h0000, "u2_3x0"});
    vecs.push_back('{1, 1'b0, 8'h03, 8'h01, 16'h0003, "u2_3x1"});
    vecs.push_back('{1, 1'b0, 8'h03, 8'h02, 16'h0006, "u2_3x2"});
    vecs.push_back('{1, 1'b0, 8'h03, 8'h03, 16'h0009, "u2_3x3"});
    vecs.push_back('{1, 1'b1, 8'h02, 8'h02, 16'h0004, "s2_m2_m2"});
    vecs.push_back('{1, 1'b1, 8'h03, 8'h01, 16'h000F, "s2_m1_1"});
    vecs.push_back('{1, 1'b1, 8'h02, 8'h01, 16'h000E, "s2_m2_1"});

    m8.start = 1'b0; m8.signed_mode = 1'b0; m8.a = '0; m8.b = '0;
    m2.start = 1'b0; m2.signed_mode = 1'b0; m2.a = '0; m2.b = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy8", 32'(m8.busy), 32'd0);
    check("rst_done8", 32'(m8.done), 32'd0);
    check("rst_c8",    32'(m8.c),    32'd0);
    check("rst_busy2", 32'(m2.busy), 32'd0);
    check("rst_c2",    32'(m2.c),    32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors.
    foreach (vecs[i]) do_op(vecs[i]);

    // start during busy is ignored; exactly one done; back-to-back accepted.
    d0 = done_cnt8;
    m8.start = 1'b1; m8.signed_mode = 1'b0; m8.a = 8'd3; m8.b = 8'd7;
    exp_q8.push_back(16'h0015);
    @(negedge clk);
    m8.start = 1'b0;
    @(negedge clk);
    m8.start = 1'b1; m8.a = 8'd9; m8.b = 8'd9;
    @(negedge clk);
    m8.a = 8'h55; m8.b = 8'hAA;
    @(negedge clk);
    m8.start = 1'b0;
    n = 0;
    while (m8.done !== 1'b1 && n < 64) begin
      n++;
      @(negedge clk);
    end
    check("busy_start_done_seen", 32'(m8.done), 32'd1);
    check("busy_start_c", 32'(m8.c), 32'h0015);
    @(negedge clk);
    v = '{0, 1'b0, 8'd5, 8'd5, 16'h0019, "b2b_5x5"};
    do_op(v);
    check("busy_start_total_dones", 32'(done_cnt8 - d0), 32'd2);

    // Asynchronous reset in the middle of an operation.
    m8.start = 1'b1; m8.signed_mode = 1'b0; m8.a = 8'h12; m8.b = 8'h34;
    @(negedge clk);
    m8.start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 32'(m8.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(m8.busy), 32'd0);
    check("mid_rst_done", 32'(m8.done), 32'd0);
    check("mid_rst_c",    32'(m8.c),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt8;
    repeat (15) @(negedge clk);
    check("post_rst_no_done", 32'(done_cnt8 - d0), 32'd0);
    check("post_rst_c", 32'(m8.c), 32'd0);
    check("post_rst_busy", 32'(m8.busy), 32'd0);
    v = '{0, 1'b1, 8'hF6, 8'h0C, 16'hFF88, "post_rst_m10_12"};
    do_op(v);

    check("queue8_drained", 32'(exp_q8.size()), 32'd0);
    check("queue2_drained", 32'(exp_q2.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_seq_multiplier

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Parametrised iterative shift-add multiplier for the ALU datapath. Multiplies two SIZE-bit operands, unsigned or two's-complement signed, into a full 2*SIZE-bit product over SIZE iteration cycles, using a start/busy/done handshake. It is the area-reduced sequential counterpart of the combinational multiplier and is selected by the ALU when a multiply opcode issues.

Parameters:
SIZE, 8, operand width in bits; legal range SIZE >= 2; product width 2*SIZE

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
a  input  SIZE  multiplicand; sampled with start
b  input  SIZE  multiplier; sampled with start
busy  output  1  high while iterating
done  output  1  one-cycle pulse when c is updated
c  output  2*SIZE  product register; holds its value until the next completion

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, busy=0, done=0, c=0, internal accumulator/counter cleared. A reset mid-operation abandons the operation; no done pulse occurs, and c=0 after release.
- FSM states: IDLE, CALC, DONE.
- IDLE: on the rising edge with start=1, latch a, b, and signed_mode. In signed mode, latch the magnitudes |a| and |b| and record neg = a[SIZE-1] XOR b[SIZE-1]. Clear the accumulator, load the iteration counter with SIZE, and go to CALC. With start=0, stay in IDLE.
- CALC: busy=1. On each edge, if the multiplier LSB is 1, add the shifted multiplicand to the 2*SIZE-bit accumulator. Then shift the multiplicand left by 1 and the multiplier right by 1, and decrement the counter. The iteration performed when the counter is 1 is the last; on that edge go to DONE.
- The DONE transition edge loads c with the final product. In signed mode with neg=1, c receives the two's-complement negation of the product, mod 2^(2*SIZE).
- DONE: busy=0, done=1 for exactly one cycle. The next edge returns to IDLE unconditionally.
- Latency: start is sampled at edge k. busy is high during cycles k+1 .. k+SIZE. c is valid and done=1 in the cycle after edge k+SIZE. Throughput is one operation per SIZE+2 cycles.
- start is ignored while in CALC or DONE. No queuing; the requester must re-assert start in IDLE.
- Changes to a, b, or signed_mode after sampling do not affect the operation in flight.
- Widths: the magnitude of the most negative signed value (2^(SIZE-1)) is represented without overflow. All products, including (-2^(SIZE-1))^2, fit in 2*SIZE bits. There is no overflow flag.
- Zero operand: the operation still takes the full SIZE iterations, and the result is 0. The sign is never negated to a nonzero value.
- c changes only on the DONE-entry edge or on reset.

Test Plan:
1. SIZE=8, unsigned, a=0xFF, b=0xFF, start pulse -> busy high for 8 cycles, then done=1 for one cycle with c=0xFE01; c holds 0xFE01 afterwards.
2. SIZE=8, signed, a=0xFD (-3), b=0x05 -> c=0xFFF1 (-15). Repeat with a=0x80, b=0x80 -> c=0x4000. Repeat with a=0x80, b=0x7F -> c=0xC080.
3. SIZE=8, unsigned, a=0x00, b=0xA5 -> done after 8 busy cycles with c=0x0000; signed a=0x00, b=0xFF -> c=0x0000.
4. SIZE=8: issue a=3, b=7; during busy, assert start with a=9, b=9 and change a/b -> done fires once with c=0x0015, and there is no second done. Issuing start in the cycle after done -> a new operation is accepted.
5. SIZE=8: start an operation; deassert rst_n at busy cycle 4 -> busy=0, done=0, and c=0 immediately (asynchronous). After release, no done pulse occurs until a new start.
6. SIZE=2, unsigned, a=2'b11 with b=00, 01, 10, 11 in turn -> c=0000, 0011, 0110, 1001, each after 2 busy cycles. Signed a=2'b10, b=2'b10 -> c=0100.
